// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode and FSM state encodings shared by the sequential ALU
package seq_alu_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_e;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider retiring one quotient bit per cycle
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, den_q, den_d;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  assign busy      = cnt_q != '0;
  assign done      = cnt_q == CW'(1);
  assign quotient  = quo_nx;
  assign remainder = rem_nx;
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, den_q};
    ge     = !diff[WIDTH];
    rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], ge};
    cnt_d  = start ? CW'(WIDTH) : busy ? cnt_q - CW'(1) : cnt_q;
    rem_d  = start ? '0 : busy ? rem_nx : rem_q;
    quo_d  = start ? a : busy ? quo_nx : quo_q;
    den_d  = start ? b : den_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      den_q <= den_d;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered add/sub/mul ALU with a multi-cycle divider behind a valid/ready port
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_value_a,
  input  logic [DATA_WIDTH-1:0] i_value_b,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [DATA_WIDTH-1:0] o_result_hi,
  output logic                  o_carry,
  output logic                  o_div_by_zero
);
  localparam int W = DATA_WIDTH;
  state_e          state_q, state_d;
  op_e             op;
  logic            accept, start_div, div_busy, div_done;
  logic [W-1:0]    quo, rem;
  logic [W-1:0]    result_q, result_d, hi_q, hi_d;
  logic            valid_q, valid_d, carry_q, carry_d, dbz_q, dbz_d;
  logic [W:0]      sum;
  logic [2*W-1:0]  prod;
  seq_divider #(.WIDTH(W)) u_div (
    .clk       (i_clk),
    .rst       (i_reset),
    .start     (start_div),
    .a         (i_value_a),
    .b         (i_value_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == ST_IDLE ? (start_div ? ST_DIV : ST_IDLE)
                                 : (div_busy && !div_done ? ST_DIV : ST_IDLE);
  end
  always_comb begin
    o_ready = state_q == ST_IDLE && !i_reset;
  end
  always_comb begin
    op        = op_e'(i_op);
    accept    = i_valid && o_ready;
    start_div = accept && op == OP_DIV && i_value_b != '0;
    sum       = {1'b0, i_value_a} + {1'b0, i_value_b};
    prod      = {{W{1'b0}}, i_value_a} * {{W{1'b0}}, i_value_b};
    valid_d   = div_done || (accept && !start_div);
    result_d  = result_q;
    hi_d      = hi_q;
    carry_d   = carry_q;
    dbz_d     = dbz_q;
    if (div_done) begin
      result_d = quo;
      hi_d     = rem;
      carry_d  = 1'b0;
      dbz_d    = 1'b0;
    end else if (valid_d) begin
      result_d = op == OP_ADD ? sum[W-1:0] : op == OP_SUB ? i_value_a - i_value_b
               : op == OP_MUL ? prod[W-1:0] : '1;
      hi_d     = op == OP_MUL ? prod[2*W-1:W] : op == OP_DIV ? i_value_a : '0;
      carry_d  = op == OP_ADD ? sum[W] : op == OP_SUB && i_value_a < i_value_b;
      dbz_d    = op == OP_DIV;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      carry_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      carry_q  <= carry_d;
      dbz_q    <= dbz_d;
    end
  end
  assign o_valid       = valid_q;
  assign o_result      = result_q;
  assign o_result_hi   = hi_q;
  assign o_carry       = carry_q;
  assign o_div_by_zero = dbz_q;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the team's combinational add/sub/mul/div block. It exposes one shared operand/opcode port with a valid/ready handshake. Add, sub and mul complete in one cycle. Divide runs on a multi-cycle restoring divider (one quotient bit per cycle), which removes the combinational divider from timing paths. It also reports carry/borrow, the high half of the product, the remainder and a divide-by-zero flag.

Parameters:
DATA_WIDTH, 8, operand/result width in bits (>= 2)

Ports:
i_clk  input  1  single clock, all logic rising-edge
i_reset  input  1  synchronous, active-high reset
i_valid  input  1  operation request
o_ready  output  1  block can accept a request this cycle
i_op  input  2  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV
i_value_a  input  DATA_WIDTH  operand A (dividend)
i_value_b  input  DATA_WIDTH  operand B (divisor)
o_valid  output  1  one-cycle pulse: result fields valid
o_result  output  DATA_WIDTH  sum / difference / low product / quotient
o_result_hi  output  DATA_WIDTH  high product (MUL), remainder (DIV), 0 for ADD/SUB
o_carry  output  1  ADD carry-out, SUB borrow (A<B), else 0
o_div_by_zero  output  1  DIV with B==0

Behaviour:
- Reset behaviour:
  - i_reset is sampled on the rising edge of i_clk, so it is synchronous.
  - It forces state IDLE, o_valid=0, o_result=0, o_result_hi=0, o_carry=0, o_div_by_zero=0, and clears the divider counter and working registers.
- States: IDLE and DIV. o_ready = (state==IDLE) && !i_reset. A request is accepted in any cycle where i_valid && o_ready.
- Cycle 0 is the accept cycle.
- ADD/SUB/MUL:
  - Results register at the end of cycle 0, and o_valid=1 in cycle 1. State stays IDLE, so throughput is one operation per cycle back-to-back.
  - ADD: {o_carry,o_result} = A+B, a (DATA_WIDTH+1)-bit sum.
  - SUB: o_result = (A-B) mod 2^DATA_WIDTH; o_carry = (A<B).
  - MUL: the full 2*DATA_WIDTH-bit product goes to {o_result_hi,o_result}.
- DIV with B==0:
  - No iteration is performed; this case has 1-cycle latency like ADD.
  - o_result = all ones, o_result_hi = A, o_div_by_zero = 1.
- DIV with B!=0:
  - A, B and the count DATA_WIDTH latch at the end of cycle 0, and state moves to DIV.
  - Cycles 1..DATA_WIDTH each perform one restoring step: shift the remainder left by the next dividend MSB, subtract B if it is >= B, set the quotient bit, and decrement the count.
  - On the last step, quotient and remainder are written to o_result and o_result_hi, and state returns to IDLE.
  - o_valid=1 in cycle DATA_WIDTH+1, and o_ready is high again in that same cycle, so a new request may be accepted there.
- o_ready is 0 in cycles 1..DATA_WIDTH. i_valid during those cycles is ignored, not queued.
- o_valid is a single-cycle pulse with no backpressure.
- Result fields hold their last values while o_valid=0. Flags not relevant to the completed op are 0 when o_valid=1.
- Reset during a division aborts it: no o_valid is produced for the aborted op, and the first cycle after reset deasserts has o_ready=1.
- i_op is only sampled on accept. Operands are unsigned. All arithmetic wraps at DATA_WIDTH except the explicit carry and high-half outputs.

Decomposition:
- Package seq_alu_pkg holds:
  - op encodings OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_DIV=2'd3
  - state encodings ST_IDLE, ST_DIV
- One sub-module, seq_divider, owns the restoring-division datapath and counter. Its interface is start, A, B, busy, done, quotient, remainder, and it uses the same clock and reset.
- The top level holds the handshake, the one-cycle ops, the divide-by-zero bypass and the output registers.

Test Plan:
- Add, DATA_WIDTH=8: A=200, B=100, op ADD, accept in cycle 0 -> cycle 1: o_valid=1, o_result=44, o_carry=1.
- Sub/mul back-to-back: SUB 5-7 then MUL 20*15 in consecutive cycles -> o_result=254, o_carry=1; next cycle o_result=44, o_result_hi=1. o_ready stays 1 throughout.
- Divide: DIV 200/7 -> o_ready=0 in cycles 1-8, o_valid in cycle 9 with o_result=28 and o_result_hi=4. An ADD request in cycle 3 is ignored (no extra o_valid). An ADD 1+1 presented in cycle 9 is accepted, giving o_result=2 in cycle 10.
- Divide by zero: DIV 55/0 -> cycle 1: o_valid=1, o_result=255, o_result_hi=55, o_div_by_zero=1, o_ready never drops.
- Reset mid-division: DIV 255/3 accepted, i_reset=1 in cycle 4 -> no o_valid ever for that op, all outputs 0. Cycle after reset deasserts: o_ready=1, and DIV 9/2 gives quotient 4, remainder 1 after 8 busy cycles.
- Divide boundaries: DIV 255/1 -> quotient 255, remainder 0; DIV 3/200 -> quotient 0, remainder 3.
